// File: rtl/de_emphasis.sv
// rtl/de_emphasis.sv - first-order de-emphasis IIR y(t) = x(t) + a*y(t-1), 4-state FSM
// Optional DE_EMPHASIS_SATURATE_EN: clamp output and pulse sat_event; otherwise wrap.
module de_emphasis #(
    parameter int                         DATA_W = 16,
    parameter int                         COEF_W = 16,
    parameter int                         FRAC   = 15,
    parameter logic signed [COEF_W-1:0]   COEF   = 16'sd31785
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tvalid_input_stream,
    output logic                     tready_input_stream,
    input  logic signed [DATA_W-1:0] input_stream,
    input  logic                     clear_state,
    output logic                     tvalid_restored_stream,
    input  logic                     tready_restored_stream,
    output logic signed [DATA_W-1:0] restored_stream,
    output logic                     sat_event
);

    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [PW:0] RND = {{(PW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`ifdef DE_EMPHASIS_SATURATE_EN
    localparam logic signed [PW:0] SMAX = {{(PW-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW:0] SMIN = {{(PW-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, MULT, ADD, OUT} state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  x_q, x_d;
    logic signed [PW-1:0]      p_q, p_d;
    logic signed [DATA_W-1:0]  y_prev_q, y_prev_d;
    logic                      clear_pending_q, clear_pending_d;
    logic signed [DATA_W-1:0]  restored_q, restored_d;
    logic                      tvalid_out_q, tvalid_out_d;
    logic                      sat_q, sat_d;
    logic                      tready_in_q, tready_in_d;

    logic signed [PW-1:0]      y_ext, coef_ext;
    logic signed [PW:0]        p_rnd, r_w, s_w;
    logic signed [DATA_W-1:0]  y_new;
    logic                      sat_now;

    // Datapath: rounded product plus captured sample, evaluated wide enough never to overflow
    always_comb begin
        y_ext    = PW'(y_prev_q);
        coef_ext = PW'(COEF);
        p_rnd    = (PW+1)'(p_q) + RND;
        r_w      = p_rnd >>> FRAC;
        s_w      = (PW+1)'(x_q) + r_w;
`ifdef DE_EMPHASIS_SATURATE_EN
        if (s_w > SMAX) begin
            y_new   = DATA_W'(SMAX);
            sat_now = 1'b1;
        end else if (s_w < SMIN) begin
            y_new   = DATA_W'(SMIN);
            sat_now = 1'b1;
        end else begin
            y_new   = DATA_W'(s_w);
            sat_now = 1'b0;
        end
`else
        y_new   = DATA_W'(s_w);
        sat_now = 1'b0;
`endif
    end

    always_comb begin
        state_d         = state_q;
        x_d             = x_q;
        p_d             = p_q;
        y_prev_d        = y_prev_q;
        clear_pending_d = clear_pending_q;
        restored_d      = restored_q;
        tvalid_out_d    = tvalid_out_q;
        sat_d           = 1'b0;
        tready_in_d     = tready_in_q;
        case (state_q)
            IDLE: begin
                tready_in_d = 1'b1;
                if (clear_state) y_prev_d = '0;
                if (tvalid_input_stream && tready_in_q) begin
                    x_d         = input_stream;
                    tready_in_d = 1'b0;
                    state_d     = MULT;
                end
            end
            MULT: begin
                if (clear_state) clear_pending_d = 1'b1;
                p_d     = y_ext * coef_ext;
                state_d = ADD;
            end
            ADD: begin
                if (clear_state) clear_pending_d = 1'b1;
                restored_d   = y_new;
                y_prev_d     = y_new;
                sat_d        = sat_now;
                tvalid_out_d = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                if (clear_state) clear_pending_d = 1'b1;
                // A clear requested while busy only takes effect once the sample leaves
                if (tready_restored_stream) begin
                    tvalid_out_d    = 1'b0;
                    tready_in_d     = 1'b1;
                    state_d         = IDLE;
                    clear_pending_d = 1'b0;
                    if (clear_pending_q || clear_state) y_prev_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            x_q             <= '0;
            p_q             <= '0;
            y_prev_q        <= '0;
            clear_pending_q <= 1'b0;
            restored_q      <= '0;
            tvalid_out_q    <= 1'b0;
            sat_q           <= 1'b0;
            tready_in_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            p_q             <= p_d;
            y_prev_q        <= y_prev_d;
            clear_pending_q <= clear_pending_d;
            restored_q      <= restored_d;
            tvalid_out_q    <= tvalid_out_d;
            sat_q           <= sat_d;
            tready_in_q     <= tready_in_d;
        end
    end

    assign tready_input_stream    = tready_in_q;
    assign tvalid_restored_stream = tvalid_out_q;
    assign restored_stream        = restored_q;
    assign sat_event              = sat_q;

endmodule
